// File: rtl/sram_dma_copy.sv
// Block-copy engine: moves LEN words from a registered-read source SRAM into a destination SRAM, one word per clock.
// Optional constant-fill mode is compiled in with `define SRAM_DMA_FILL_EN.
module sram_dma_copy #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  RESETn,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] SRC_BASE,
  input  logic [ADDR_WIDTH-1:0] DST_BASE,
  input  logic [ADDR_WIDTH:0]   LEN,
  input  logic                  HOLD,
`ifdef SRAM_DMA_FILL_EN
  input  logic                  FILL,
  input  logic [DATA_WIDTH-1:0] FILL_DATA,
`endif
  output logic [ADDR_WIDTH-1:0] SRC_ADDR,
  output logic                  SRC_CEn,
  output logic                  SRC_OEn,
  input  logic [DATA_WIDTH-1:0] SRC_Q,
  output logic [ADDR_WIDTH-1:0] DST_ADDR,
  output logic [DATA_WIDTH-1:0] DST_DATA,
  output logic                  DST_CEn,
  output logic                  DST_WEn,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
  logic [ADDR_WIDTH:0]   rem;
  logic                  pend;
  logic                  fill_mode;
  logic                  rd_en, wr_en;

`ifdef SRAM_DMA_FILL_EN
  logic                  fill_q;
  logic [DATA_WIDTH-1:0] fill_data_q;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (state == IDLE && START && LEN != '0) begin
      fill_q      <= FILL;
      fill_data_q <= FILL_DATA;
    end else if (state == FIN) begin
      fill_q      <= 1'b0;
    end
  end

  assign fill_mode = fill_q;
  assign DST_DATA  = fill_q ? fill_data_q : SRC_Q;
`else
  assign fill_mode = 1'b0;
  assign DST_DATA  = SRC_Q;
`endif

  // State register
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; HOLD freezes RUN and FLUSH in place
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START) state_nxt = (LEN == '0) ? FIN : RUN;
      RUN:     if (!HOLD && rem == REM_ONE) state_nxt = fill_mode ? FIN : FLUSH;
      FLUSH:   if (!HOLD) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: strobes are combinational so an async reset releases them at once
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    rd_en = 1'b0;
    wr_en = 1'b0;
    BUSY  = 1'b0;
    DONE  = 1'b0;
    unique case (state)
      RUN: begin
        BUSY  = 1'b1;
        rd_en = !HOLD && !fill_mode;
        wr_en = !HOLD && (pend || fill_mode);
      end
      FLUSH: begin
        BUSY  = 1'b1;
        wr_en = !HOLD;
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
    SRC_CEn = !rd_en;
    SRC_OEn = !rd_en;
    DST_CEn = !wr_en;
    DST_WEn = !wr_en;
  end

  assign SRC_ADDR = src_ptr;
  assign DST_ADDR = dst_ptr;

  // Pointers, remaining count and the one-word pipeline flag
  always_ff @(posedge clk or negedge RESETn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!RESETn) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      rem     <= '0;
      pend    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (START && LEN != '0) begin
          src_ptr <= SRC_BASE;
          dst_ptr <= DST_BASE;
          rem     <= LEN;
          pend    <= 1'b0;
        end
        RUN: if (!HOLD) begin
          rem <= rem - REM_ONE;
          if (rd_en) begin
            src_ptr <= src_ptr + 1'b1;
            pend    <= 1'b1;
          end
          if (wr_en) dst_ptr <= dst_ptr + 1'b1;
        end
        FLUSH: if (!HOLD) begin
          dst_ptr <= dst_ptr + 1'b1;
          pend    <= 1'b0;
        end
        default: pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_dma_copy.sv
// Scoreboard bench for sram_dma_copy: behavioural SRAMs, expected read/write queues and a negedge monitor.
// Define SRAM_DMA_FILL_EN to also exercise the fill mode.
module tb_sram_dma_copy;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          RESETn = 1'b0;
  logic          START = 1'b0;
  logic          HOLD = 1'b0;
  logic [AW-1:0] SRC_BASE = '0, DST_BASE = '0;
  logic [AW:0]   LEN = '0;
  logic          FILL = 1'b0;
  logic [DW-1:0] FILL_DATA = '0;
  logic [AW-1:0] SRC_ADDR, DST_ADDR;
  logic [DW-1:0] DST_DATA;
  logic [DW-1:0] src_q = 8'h5A;
  logic          SRC_CEn, SRC_OEn, DST_CEn, DST_WEn, BUSY, DONE;

  logic [DW-1:0] src_mem [DEPTH];
  logic [DW-1:0] dst_mem [DEPTH];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  int tests = 0, fails = 0, wr_seen = 0;

  sram_dma_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .RESETn(RESETn), .START(START),
    .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .LEN(LEN), .HOLD(HOLD),
`ifdef SRAM_DMA_FILL_EN
    .FILL(FILL), .FILL_DATA(FILL_DATA),
`endif
    .SRC_ADDR(SRC_ADDR), .SRC_CEn(SRC_CEn), .SRC_OEn(SRC_OEn), .SRC_Q(src_q),
    .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA), .DST_CEn(DST_CEn), .DST_WEn(DST_WEn),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural sync SRAMs: registered read data holds while OEn is high
  always @(posedge clk) begin
    if (!SRC_CEn && !SRC_OEn) src_q <= src_mem[SRC_ADDR];
    if (!DST_CEn && !DST_WEn) dst_mem[DST_ADDR] <= DST_DATA;
  end

  // Monitor: every strobe must match the next expected access in order
  always @(negedge clk) begin
    if (RESETn) begin
      if (HOLD) check("hold_strobes", {SRC_CEn, SRC_OEn, DST_CEn, DST_WEn}, 4'hF);
      if (!SRC_CEn || !SRC_OEn) begin
        check("read_strobe_pair", {SRC_CEn, SRC_OEn}, 2'b00);
        check("read_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("read_addr", SRC_ADDR, rd_q.pop_front());
      end
      if (!DST_CEn || !DST_WEn) begin
        check("write_strobe_pair", {DST_CEn, DST_WEn}, 2'b00);
        check("write_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          wr_t e;
          e = wr_q.pop_front();
          check("write_addr", DST_ADDR, e.addr);
          check("write_data", DST_DATA, e.data);
        end
        wr_seen++;
      end
    end
  end

  task automatic push_expect(input logic [AW-1:0] sb, input logic [AW-1:0] db, input int len,
                             input bit fill, input logic [DW-1:0] fd);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] sa, da;
      sa = AW'(int'(sb) + i);
      da = AW'(int'(db) + i);
      if (fill) wr_q.push_back('{addr: da, data: fd});
      else begin
        rd_q.push_back(sa);
        wr_q.push_back('{addr: da, data: src_mem[sa]});
      end
    end
  endtask

  // hold_mode: 0 none, 1 cycles 3..5, 2 random; spurious_at: cycle to pulse an ignored START
  task automatic do_copy(input logic [AW-1:0] sb, input logic [AW-1:0] db, input int len,
                         input bit fill, input logic [DW-1:0] fd,
                         input int hold_mode, input int spurious_at);
    int base_busy, h, busy_cnt, done_cyc, w0, c;
    bit hv;
    h = 0; busy_cnt = 0; done_cyc = 0; w0 = wr_seen;
    base_busy = (len == 0) ? 0 : (fill ? len : len + 1);
    push_expect(sb, db, len, fill, fd);
    @(posedge clk); #1;
    SRC_BASE = sb; DST_BASE = db; LEN = (AW+1)'(len); FILL = fill; FILL_DATA = fd; START = 1'b1;
    @(posedge clk); #1;
    for (c = 1; c < 2 * len + 60; c++) begin
      hv = 1'b0;
      if (base_busy != 0 && c <= base_busy + h) begin
        if (hold_mode == 1) hv = (c >= 3 && c <= 5);
        else if (hold_mode == 2) hv = ($urandom_range(3) == 0) && (h < 6);
      end
      HOLD = hv;
      h += int'(hv);
      if (c == spurious_at) begin
        START = 1'b1; SRC_BASE = AW'($urandom); DST_BASE = AW'($urandom); LEN = 11'd5;
      end else START = 1'b0;
      @(negedge clk);
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    HOLD = 1'b0; START = 1'b0;
    check("done_cycle", done_cyc, base_busy + h + 1);
    check("busy_cycles", busy_cnt, base_busy + h);
    check("write_count", wr_seen - w0, len);
    check("writes_left", wr_q.size(), 0);
    check("reads_left", rd_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", {DONE, BUSY}, 2'b00);
  endtask

  initial begin
    int w0, dones;
    for (int i = 0; i < DEPTH; i++) begin
      src_mem[i] = DW'($urandom);
      dst_mem[i] = DW'($urandom);
    end

    #12;
    check("reset_strobes", {SRC_CEn, SRC_OEn, DST_CEn, DST_WEn}, 4'hF);
    check("reset_addrs", {SRC_ADDR, DST_ADDR}, '0);
    check("reset_busy_done", {BUSY, DONE}, 2'b00);
    check("reset_dst_data", DST_DATA, 8'h5A);
    @(posedge clk); #1 RESETn = 1'b1;

    do_copy(10'h010, 10'h200, 4, 1'b0, '0, 0, 0);
    do_copy(10'h123, 10'h321, 0, 1'b0, '0, 0, 0);
    do_copy(10'h3FE, 10'h3FF, 3, 1'b0, '0, 0, 0);
    do_copy(10'h040, 10'h140, 8, 1'b0, '0, 1, 4);

    // Reset in the middle of an 8-word copy after three writes
    w0 = wr_seen;
    push_expect(10'h080, 10'h180, 8, 1'b0, '0);
    @(posedge clk); #1;
    SRC_BASE = 10'h080; DST_BASE = 10'h180; LEN = 11'd8; START = 1'b1;
    @(posedge clk); #1 START = 1'b0;
    for (int k = 0; k < 40 && wr_seen < w0 + 3; k++) begin
      @(negedge clk); #1;
    end
    check("mid_reset_writes", wr_seen - w0, 3);
    #1 RESETn = 1'b0;
    #1;
    check("mid_reset_strobes", {SRC_CEn, SRC_OEn, DST_CEn, DST_WEn}, 4'hF);
    check("mid_reset_busy", BUSY, 1'b0);
    wr_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1 RESETn = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      dones += int'(DONE);
    end
    check("mid_reset_no_done", dones, 0);
    do_copy(10'h080, 10'h180, 8, 1'b0, '0, 0, 0);

    for (int t = 0; t < 10; t++)
      do_copy(AW'($urandom), AW'($urandom), (t == 4) ? 0 : int'($urandom_range(40, 1)),
              1'b0, '0, 2, 0);
    do_copy(10'h155, 10'h2AA, DEPTH, 1'b0, '0, 2, 0);

`ifdef SRAM_DMA_FILL_EN
    begin
      int nz;
      do_copy(10'h000, 10'h000, DEPTH, 1'b1, 8'h00, 0, 0);
      @(posedge clk); #1;
      nz = 0;
      for (int i = 0; i < DEPTH; i++) nz += int'(dst_mem[i] != 8'h00);
      check("fill_cleared", nz, 0);
      do_copy(10'h3F0, 10'h3FC, 9, 1'b1, 8'hC3, 2, 0);
      do_copy(10'h020, 10'h060, 6, 1'b0, '0, 0, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
